issue_scoreboard: RTL

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

---
 rtl/issue_scoreboard.sv | 113 +++++++++++
 1 files changed

// File: rtl/issue_scoreboard.sv
// Dual-issue scoreboard: one countdown counter per architectural register
// tracks when a long-latency result becomes forwardable and gates issue of
// the older (A) and younger (B) slots accordingly.
// Optional statistics counters are enabled by defining ISSUE_STAT_EN.
module issue_scoreboard #(
  parameter int unsigned LD_LAT = 1,
  parameter int unsigned MD_LAT = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] i_valid,
  input  logic [4:0] i_rd_a,
  input  logic [4:0] i_rd_b,
  input  logic       i_we_a,
  input  logic       i_we_b,
  input  logic [4:0] i_rs1_a,
  input  logic [4:0] i_rs2_a,
  input  logic [4:0] i_rs1_b,
  input  logic [4:0] i_rs2_b,
  input  logic [1:0] i_cls_a,
  input  logic [1:0] i_cls_b,
  input  logic       i_ld_a,
  input  logic       i_ld_b,
  input  logic       i_stall,
  input  logic       i_flush,
  output logic [1:0] o_issue,
  output logic [1:0] o_usingNUM
`ifdef ISSUE_STAT_EN
  ,
  output logic [31:0] o_cnt_dual,
  output logic [31:0] o_cnt_hzd
`endif
);

  localparam int unsigned MaxLat = (LD_LAT > MD_LAT) ? LD_LAT : MD_LAT;
  localparam int unsigned CW     = $clog2(MaxLat + 1);

  localparam logic [1:0] ClsAlu = 2'd0;
  localparam logic [1:0] ClsMd  = 2'd2;
  localparam logic [1:0] ClsBr  = 2'd3;

  // Entry 0 is never written with a nonzero value, so r0 is never pending.
  logic [CW-1:0] cnt_q [32];
  logic [CW-1:0] cnt_d [32];

  logic          hzd_a, hzd_b, raw_ab;
  logic          grant_a, grant_b;
  logic [CW-1:0] lat_a, lat_b;

  // Source hazard detection and issue grant.
  always_comb begin
    hzd_a = ((i_rs1_a != 5'd0) && (cnt_q[i_rs1_a] != '0)) ||
            ((i_rs2_a != 5'd0) && (cnt_q[i_rs2_a] != '0));
    hzd_b = ((i_rs1_b != 5'd0) && (cnt_q[i_rs1_b] != '0)) ||
            ((i_rs2_b != 5'd0) && (cnt_q[i_rs2_b] != '0));
    raw_ab = i_we_a && (i_rd_a != 5'd0) && ((i_rd_a == i_rs1_b) || (i_rd_a == i_rs2_b));
    // Gated by rstn so outputs read zero while reset is held.
    grant_a = rstn && i_valid[1] && !hzd_a && !i_stall && !i_flush;
    grant_b = grant_a && i_valid[0] && !hzd_b && (i_cls_a == ClsAlu) &&
              !((i_cls_a == ClsBr) && (i_cls_b == ClsBr)) && !raw_ab;
    o_issue    = {grant_a, grant_b};
    o_usingNUM = {1'b0, grant_a} + {1'b0, grant_b};
  end

  // Result latency of each slot as seen by dependents.
  always_comb begin
    lat_a = i_ld_a ? CW'(LD_LAT) : ((i_cls_a == ClsMd) ? CW'(MD_LAT) : '0);
    lat_b = i_ld_b ? CW'(LD_LAT) : ((i_cls_b == ClsMd) ? CW'(MD_LAT) : '0);
  end

  // Counter next state: flush clears, stall holds, otherwise decrement then
  // load newly issued writers (B last so it wins on a shared rd).
  always_comb begin
    cnt_d = cnt_q;
    if (i_flush) begin
      for (int i = 0; i < 32; i++) cnt_d[i] = '0;
    end else if (!i_stall) begin
      for (int i = 1; i < 32; i++) begin
        if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CW'(1);
      end
      if (grant_a && i_we_a && (i_rd_a != 5'd0)) cnt_d[i_rd_a] = lat_a;
      if (grant_b && i_we_b && (i_rd_b != 5'd0)) cnt_d[i_rd_b] = lat_b;
    end
  end

  // Counter state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef ISSUE_STAT_EN
  logic [31:0] cnt_dual_q, cnt_hzd_q;

  // Dual-issue and A-hazard cycle statistics; frozen while stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_dual_q <= '0;
      cnt_hzd_q  <= '0;
    end else if (!i_stall) begin
      if (o_usingNUM == 2'd2)   cnt_dual_q <= cnt_dual_q + 32'd1;
      if (i_valid[1] && hzd_a)  cnt_hzd_q  <= cnt_hzd_q + 32'd1;
    end
  end

  assign o_cnt_dual = cnt_dual_q;
  assign o_cnt_hzd  = cnt_hzd_q;
`endif

endmodule
